educell_syndir_arb: RTL and testbench
=====================================

# educell_syndir_arb

Registered, parametrised syndrome-direction arbiter for the EDU cell. It samples NDIR incoming spike lines and selects exactly one winner, by either fixed priority or round-robin. The winning direction is held as a one-hot `syndir` until the cell clears it, and the block flags conflicting and dropped spikes. It replaces the combinational fixed-priority direction encoder in the EDU cell and feeds the cell's syndrome-matching logic.

## Interface
Parameters:
- `NDIR`, 6: number of spike directions. Legal range is ≥2. With 6, the index order is 0=s, 1=n, 2=se, 3=sw, 4=ne, 5=nw.
- `PRIO_MODE`, 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin.
- `CNT_W`, 8: width of the capture counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `spike_in`  in  NDIR  spike lines, one per direction. Level-sampled on `clk`.
- `capture_en`  in  1  enables capture while IDLE.
- `clear`  in  1  releases the held direction and clears the sticky flags.
- `syndir`  out  NDIR  registered one-hot winner. All zero when not valid.
- `syndir_valid`  out  1  high while a direction is held.
- `multi_hit`  out  1  sticky flag: the capture cycle saw more than one spike.
- `dropped`  out  1  sticky flag: a spike arrived while HELD.
- `cap_cnt`  out  CNT_W  saturating count of captures since reset.

## Operation
- The FSM has two states: IDLE and HELD.
- IDLE → HELD when `capture_en` && `spike_in` != 0 && !`clear`.
  - On that edge, `syndir` is loaded with the one-hot winner.
  - `syndir_valid` is set to 1.
  - `multi_hit` is set to (popcount(`spike_in`) > 1).
  - `cap_cnt` increments, saturating at 2^CNT_W−1.
- HELD → IDLE when `clear` = 1. On that edge `syndir`, `syndir_valid`, `multi_hit` and `dropped` all go to 0.
- In HELD with !`clear` and `spike_in` != 0, `dropped` is set to 1 and stays set until `clear`. `syndir` is unchanged.
- `clear` has priority over capture in every state. A cycle with `clear` = 1 never captures, even in IDLE.
- In IDLE with `capture_en` = 0, spikes are ignored and no flag is set.
- Fixed priority (`PRIO_MODE` = 0): the winner is the lowest set index of `spike_in`.
- Round-robin (`PRIO_MODE` = 1):
  - The search starts at pointer `rr_ptr` (width clog2(NDIR)) and runs upward, wrapping from NDIR−1 to 0.
  - The winner is the first set bit found.
  - On each capture, `rr_ptr` ← (winner+1) mod NDIR, wrapping correctly when NDIR is not a power of 2.
  - `rr_ptr` changes only on capture.
- In mode 0, `rr_ptr` is not implemented.

## Timing
- Reset values:
  - `syndir` = 0
  - `syndir_valid` = 0
  - `multi_hit` = 0
  - `dropped` = 0
  - `cap_cnt` = 0
  - `rr_ptr` = 0
  - state = IDLE
- Capture latency is 1 cycle. A spike sampled at edge k shows on `syndir` / `syndir_valid` after edge k, with no combinational input-to-output path.
- The minimum capture-to-recapture spacing is 2 edges: one edge for the capture, one for `clear`. The next capture can happen on the edge after the clear edge.
- Reset asserted mid-HELD returns every output to its reset value immediately, without waiting for `clk`.
- When `cap_cnt` is at max, a capture leaves it at max. There is no wrap.

## Test plan
- Reset/idle check, NDIR=6, mode 0: release `rst` with `spike_in`=0 and `capture_en`=1 for 5 cycles → all outputs stay 0. Assert `rst` while HELD → outputs go to 0 before the next edge.
- Fixed priority, NDIR=6, mode 0: `spike_in`=6'b101100 with `capture_en` → next cycle `syndir`=6'b000100, `syndir_valid`=1, `multi_hit`=1, `cap_cnt`=1.
- Hold/drop/clear: while HELD, drive `spike_in`=6'b000001 → `syndir` unchanged and `dropped`=1. Pulse `clear` → next cycle all flags and `syndir` are 0. Assert `clear` together with a spike in IDLE → no capture.
- Round-robin, NDIR=6, mode 1: hold `spike_in`=6'b100011 across repeated capture/clear pairs → winners are 6'b000001, then 6'b000010, then 6'b100000, then 6'b000001 (wrap). `rr_ptr` sequence is 1, 2, 0, 1.
- Non-power-of-2 wrap, NDIR=5, mode 1: single spike on bit 4, captured → `rr_ptr`=0. Then `spike_in`=5'b10001 → winner is 5'b00001.
- Saturation, CNT_W=2: 5 capture/clear pairs → `cap_cnt` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/educell_syndir_arb_if.sv
//------------------------------------------------------------------------------
// Module      : educell_syndir_arb_if
// Description : Spike-direction arbiter bus: spike/control inputs and the
//               held direction, flags and capture counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface educell_syndir_arb_if #(
  parameter int NDIR  = 6,
  parameter int CNT_W = 8
);
  logic [NDIR-1:0]  spike_in;
  logic             capture_en;
  logic             clear;
  logic [NDIR-1:0]  syndir;
  logic             syndir_valid;
  logic             multi_hit;
  logic             dropped;
  logic [CNT_W-1:0] cap_cnt;

  modport master (
    output spike_in, capture_en, clear,
    input  syndir, syndir_valid, multi_hit, dropped, cap_cnt
  );

  modport slave (
    input  spike_in, capture_en, clear,
    output syndir, syndir_valid, multi_hit, dropped, cap_cnt
  );
endinterface

`default_nettype wire

// File: rtl/educell_syndir_arb.sv
//------------------------------------------------------------------------------
// Module      : educell_syndir_arb
// Description : Registered one-hot spike-direction arbiter (fixed priority or
//               round-robin) with hold/clear, sticky flags and capture count.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module educell_syndir_arb #(
  parameter int NDIR      = 6,
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  educell_syndir_arb_if.slave   bus
);

  localparam int   c_PTR_W = $clog2(NDIR);
  localparam logic c_IDLE  = 1'b0;
  localparam logic c_HELD  = 1'b1;

  logic             r_state;
  logic             w_state_nxt;
  logic             w_capture;
  logic             w_drop;
  logic             w_any;
  logic             w_multi;
  logic             w_found;
  int               w_probe;
  logic [c_PTR_W-1:0] w_rr_base;
  logic [c_PTR_W-1:0] w_win_idx;
  logic [NDIR-1:0]    w_win_oh;

  logic [NDIR-1:0]  r_syndir;
  logic             r_valid;
  logic             r_multi;
  logic             r_drop;
  logic [CNT_W-1:0] r_cap_cnt;

  assign w_any   = |bus.spike_in;
  assign w_multi = |(bus.spike_in & (bus.spike_in - 1'b1));

  // Search upward from the base index with wrap; fixed priority uses base 0.
  always_comb begin
    w_win_idx = '0;
    w_found   = 1'b0;
    w_probe   = 0;
    for (int i = 0; i < NDIR; i++) begin
      if (!w_found) begin
        w_probe = int'(w_rr_base) + i;
        if (w_probe >= NDIR) w_probe = w_probe - NDIR;
        if (bus.spike_in[w_probe]) begin
          w_found   = 1'b1;
          w_win_idx = c_PTR_W'(w_probe);
        end
      end
    end
  end

  assign w_win_oh = {{(NDIR-1){1'b0}}, 1'b1} << w_win_idx;

  generate
    if (PRIO_MODE == 1) begin : g_rr
      logic [c_PTR_W-1:0] r_rr_ptr;
      logic [c_PTR_W-1:0] w_rr_nxt;

      assign w_rr_nxt  = (w_win_idx == c_PTR_W'(NDIR - 1)) ? '0 : w_win_idx + 1'b1;
      assign w_rr_base = r_rr_ptr;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_rr_ptr <= '0;
        else if (w_capture) r_rr_ptr <= w_rr_nxt;
      end
    end else begin : g_fixed
      assign w_rr_base = '0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; clear always wins over capture
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (!bus.clear && bus.capture_en && w_any) w_state_nxt = c_HELD;
      c_HELD:  if (bus.clear) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Per-state action decode
  always_comb begin
    w_capture = 1'b0;
    w_drop    = 1'b0;
    case (r_state)
      c_IDLE:  w_capture = !bus.clear && bus.capture_en && w_any;
      c_HELD:  w_drop    = !bus.clear && w_any;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_syndir  <= '0;
      r_valid   <= 1'b0;
      r_multi   <= 1'b0;
      r_drop    <= 1'b0;
      r_cap_cnt <= '0;
    end else if (bus.clear) begin
      r_syndir <= '0;
      r_valid  <= 1'b0;
      r_multi  <= 1'b0;
      r_drop   <= 1'b0;
    end else if (w_capture) begin
      r_syndir <= w_win_oh;
      r_valid  <= 1'b1;
      r_multi  <= w_multi;
      if (r_cap_cnt != '1) r_cap_cnt <= r_cap_cnt + 1'b1;
    end else if (w_drop) begin
      r_drop <= 1'b1;
    end
  end

  assign bus.syndir       = r_syndir;
  assign bus.syndir_valid = r_valid;
  assign bus.multi_hit    = r_multi;
  assign bus.dropped      = r_drop;
  assign bus.cap_cnt      = r_cap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_educell_syndir_arb.sv
//------------------------------------------------------------------------------
// Module      : tb_educell_syndir_arb
// Description : Vector-table bench over four arbiter configurations.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_educell_syndir_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // a: NDIR6 fixed, b: NDIR6 rr, c: NDIR5 rr, d: NDIR6 fixed CNT_W=2
  educell_syndir_arb_if #(.NDIR(6), .CNT_W(8)) ifa ();
  educell_syndir_arb_if #(.NDIR(6), .CNT_W(8)) ifb ();
  educell_syndir_arb_if #(.NDIR(5), .CNT_W(8)) ifc ();
  educell_syndir_arb_if #(.NDIR(6), .CNT_W(2)) ifd ();

  educell_syndir_arb #(.NDIR(6), .PRIO_MODE(0), .CNT_W(8)) u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  educell_syndir_arb #(.NDIR(6), .PRIO_MODE(1), .CNT_W(8)) u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  educell_syndir_arb #(.NDIR(5), .PRIO_MODE(1), .CNT_W(8)) u_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  educell_syndir_arb #(.NDIR(6), .PRIO_MODE(0), .CNT_W(2)) u_d (.clk(clk), .rst(rst), .bus(ifd.slave));

  typedef struct {
    int         sel;
    logic [5:0] spike;
    logic       en;
    logic       clr;
    logic [5:0] syn;
    logic       v;
    logic       m;
    logic       d;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(int sel, logic [5:0] spike, logic en, logic clr,
                              logic [5:0] syn, logic v, logic m, logic d, logic [7:0] cnt);
    vec_t r;
    r.sel = sel; r.spike = spike; r.en = en; r.clr = clr;
    r.syn = syn; r.v = v; r.m = m; r.d = d; r.cnt = cnt;
    return r;
  endfunction

  task automatic drive(int sel, logic [5:0] sp, logic en, logic cl);
    ifa.spike_in = '0; ifa.capture_en = 1'b0; ifa.clear = 1'b0;
    ifb.spike_in = '0; ifb.capture_en = 1'b0; ifb.clear = 1'b0;
    ifc.spike_in = '0; ifc.capture_en = 1'b0; ifc.clear = 1'b0;
    ifd.spike_in = '0; ifd.capture_en = 1'b0; ifd.clear = 1'b0;
    case (sel)
      0: begin ifa.spike_in = sp;      ifa.capture_en = en; ifa.clear = cl; end
      1: begin ifb.spike_in = sp;      ifb.capture_en = en; ifb.clear = cl; end
      2: begin ifc.spike_in = sp[4:0]; ifc.capture_en = en; ifc.clear = cl; end
      default: begin ifd.spike_in = sp; ifd.capture_en = en; ifd.clear = cl; end
    endcase
  endtask

  // {syndir[5:0], valid, multi, dropped, cnt[7:0]}
  function automatic logic [16:0] observe(int sel);
    case (sel)
      0: return {ifa.syndir, ifa.syndir_valid, ifa.multi_hit, ifa.dropped, ifa.cap_cnt};
      1: return {ifb.syndir, ifb.syndir_valid, ifb.multi_hit, ifb.dropped, ifb.cap_cnt};
      2: return {1'b0, ifc.syndir, ifc.syndir_valid, ifc.multi_hit, ifc.dropped, ifc.cap_cnt};
      default: return {ifd.syndir, ifd.syndir_valid, ifd.multi_hit, ifd.dropped, 6'b0, ifd.cap_cnt};
    endcase
  endfunction

  task automatic check(string name, logic [16:0] act, logic [16:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got syn=%b v=%b m=%b d=%b cnt=%0d, want syn=%b v=%b m=%b d=%b cnt=%0d",
               name, act[16:11], act[10], act[9], act[8], act[7:0],
               exp[16:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // A: idle with capture_en, fixed priority, drop, clear, clear-vs-capture
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 6'b000000, 1, 0, 6'b000000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 6'b101100, 1, 0, 6'b000100, 1, 1, 0, 1));
    vecs.push_back(mk(0, 6'b000001, 1, 0, 6'b000100, 1, 1, 1, 1));
    vecs.push_back(mk(0, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 6'b000001, 1, 1, 6'b000000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 6'b000010, 0, 0, 6'b000000, 0, 0, 0, 1));
    vecs.push_back(mk(0, 6'b010000, 1, 0, 6'b010000, 1, 0, 0, 2));
    vecs.push_back(mk(0, 6'b000000, 1, 0, 6'b010000, 1, 0, 0, 2));
    vecs.push_back(mk(0, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 2));
    vecs.push_back(mk(0, 6'b000011, 1, 0, 6'b000001, 1, 1, 0, 3));
    vecs.push_back(mk(0, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 3));
    // B: round-robin over 100011, pointer 0 -> 1 -> 2 -> 0 -> 1
    vecs.push_back(mk(1, 6'b100011, 1, 0, 6'b000001, 1, 1, 0, 1));
    vecs.push_back(mk(1, 6'b100011, 1, 0, 6'b000001, 1, 1, 1, 1));
    vecs.push_back(mk(1, 6'b100011, 1, 1, 6'b000000, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6'b100011, 1, 0, 6'b000010, 1, 1, 0, 2));
    vecs.push_back(mk(1, 6'b100011, 1, 1, 6'b000000, 0, 0, 0, 2));
    vecs.push_back(mk(1, 6'b100011, 1, 0, 6'b100000, 1, 1, 0, 3));
    vecs.push_back(mk(1, 6'b100011, 1, 1, 6'b000000, 0, 0, 0, 3));
    vecs.push_back(mk(1, 6'b100011, 1, 0, 6'b000001, 1, 1, 0, 4));
    vecs.push_back(mk(1, 6'b100011, 1, 1, 6'b000000, 0, 0, 0, 4));
    // C: NDIR=5 wrap from index 4 back to 0, then pointer at 1
    vecs.push_back(mk(2, 6'b010000, 1, 0, 6'b010000, 1, 0, 0, 1));
    vecs.push_back(mk(2, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 1));
    vecs.push_back(mk(2, 6'b010001, 1, 0, 6'b000001, 1, 1, 0, 2));
    vecs.push_back(mk(2, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 2));
    vecs.push_back(mk(2, 6'b010001, 1, 0, 6'b010000, 1, 1, 0, 3));
    vecs.push_back(mk(2, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, 3));
    // D: 2-bit counter saturates at 3
    for (int k = 1; k <= 5; k++) begin
      vecs.push_back(mk(3, 6'b000100, 1, 0, 6'b000100, 1, 0, 0, (k > 3) ? 8'd3 : 8'(k)));
      vecs.push_back(mk(3, 6'b000000, 0, 1, 6'b000000, 0, 0, 0, (k > 3) ? 8'd3 : 8'(k)));
    end

    drive(0, 6'b0, 1'b1, 1'b0);
    repeat (3) step();
    check("reset_state", observe(0), 17'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].spike, vecs[i].en, vecs[i].clr);
      step();
      check($sformatf("vec%0d_sel%0d", i, vecs[i].sel), observe(vecs[i].sel),
            {vecs[i].syn, vecs[i].v, vecs[i].m, vecs[i].d, vecs[i].cnt});
    end

    // Asynchronous reset while HELD must clear outputs before the next edge
    drive(0, 6'b001000, 1'b1, 1'b0);
    step();
    check("pre_async_held", observe(0), {6'b001000, 1'b1, 1'b0, 1'b0, 8'd4});
    drive(0, 6'b000000, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", observe(0), 17'b0);
    check("async_reset_b", observe(1), 17'b0);
    step();
    rst = 1'b0;
    // Round-robin pointer back at 0 after reset
    drive(1, 6'b100011, 1'b1, 1'b0);
    step();
    check("rr_after_reset", observe(1), {6'b000001, 1'b1, 1'b1, 1'b0, 8'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
